// File: rtl/csr_intr_ctrl.sv
// csr_intr_ctrl: machine-mode CSR file and fixed-priority interrupt controller with req/ack trap handshake
module csr_intr_ctrl #(
  parameter int          NUM_EXT_IRQ = 4,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] MTVEC_RESET = 32'h0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            pc_i,
  input  logic [11:0]            csr_addr,
  input  logic [31:0]            csr_wdata,
  input  logic [1:0]             csr_op,
  output logic [31:0]            rdata,
  output logic                   csr_illegal,
  input  logic                   t_intr,
  input  logic                   e_intr,
  input  logic [NUM_EXT_IRQ-1:0] ext_irq,
  input  logic                   is_mret,
  output logic                   intr_req,
  input  logic                   intr_ack,
  output logic [31:0]            trap_vector,
  output logic [31:0]            epc
);
  localparam int NI = NUM_EXT_IRQ + 2;
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, HANDLER = 2'd2;
  localparam logic [31:0] MIE_MASK = 32'h0000_0880 | (((32'h1 << NUM_EXT_IRQ) - 32'h1) << 16);

  logic [SYNC_STAGES-1:0][NI-1:0] sync_q, sync_d;
  logic [NI-1:0] irq;
  logic [31:0] mip, pend, wr_val, tv_base;
  logic [31:0] mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d;
  logic        mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
  logic [1:0]  state_q, state_d;
  logic [4:0]  cause_q, cause_d, win, tv_cause;
  logic        we, take, any_pend;

  // Shift raw interrupt levels through the synchroniser chain; the last stage feeds mip
  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], {ext_irq, e_intr, t_intr}};

  assign irq = sync_q[SYNC_STAGES-1];

  // Place synchronised levels at their mip bit positions
  always_comb begin
    mip = '0;
    mip[7] = irq[0];
    mip[11] = irq[1];
    mip[16 +: NUM_EXT_IRQ] = irq[NI-1:2];
  end

  assign pend = mip & mie_q;
  assign any_pend = |pend;

  // Fixed priority: MEIP over MTIP over platform lines, lowest platform index first
  always_comb begin
    win = '0;
    for (int i = NUM_EXT_IRQ - 1; i >= 0; i--) if (pend[16 + i]) win = 5'(16 + i);
    if (pend[7]) win = 5'd7;
    if (pend[11]) win = 5'd11;
  end

  // Combinational CSR read and address decode
  always_comb begin
    rdata = '0;
    csr_illegal = 1'b0;
    case (csr_addr)
      12'h300: rdata = {24'b0, mst_mpie_q, 3'b0, mst_mie_q, 3'b0};
      12'h304: rdata = mie_q;
      12'h305: rdata = mtvec_q;
      12'h340: rdata = mscratch_q;
      12'h341: rdata = mepc_q;
      12'h342: rdata = mcause_q;
      12'h344: rdata = mip;
      default: csr_illegal = 1'b1;
    endcase
  end

  assign wr_val = csr_op == 2'b01 ? csr_wdata : csr_op == 2'b10 ? rdata | csr_wdata : rdata & ~csr_wdata;
  assign we = |csr_op && !csr_illegal;
  assign take = state_q == REQ && intr_ack && !is_mret;

  // CSR next values: trap entry beats mret, which beats software writes to mstatus/mepc/mcause
  always_comb begin
    mie_d = we && csr_addr == 12'h304 ? wr_val & MIE_MASK : mie_q;
    mtvec_d = we && csr_addr == 12'h305 ? {wr_val[31:2], 1'b0, wr_val[1:0] == 2'b01} : mtvec_q;
    mscratch_d = we && csr_addr == 12'h340 ? wr_val : mscratch_q;
    mepc_d = take ? pc_i & ~32'h3 : we && csr_addr == 12'h341 ? wr_val & ~32'h3 : mepc_q;
    mcause_d = take ? {1'b1, 26'b0, cause_q} : we && csr_addr == 12'h342 ? wr_val & 32'h8000_001F : mcause_q;
    mst_mie_d = take ? 1'b0 : is_mret ? mst_mpie_q : we && csr_addr == 12'h300 ? wr_val[3] : mst_mie_q;
    mst_mpie_d = take ? mst_mie_q : is_mret ? 1'b1 : we && csr_addr == 12'h300 ? wr_val[7] : mst_mpie_q;
  end

  // Trap handshake FSM; the cause is frozen while a request is outstanding
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      IDLE: if (any_pend && mst_mie_q) begin
        state_d = REQ;
        cause_d = win;
      end
      REQ: state_d = take ? HANDLER : (!any_pend || !mst_mie_q) ? IDLE : REQ;
      HANDLER: if (is_mret) state_d = IDLE;
      else if (any_pend && mst_mie_q) begin
        state_d = REQ;
        cause_d = win;
      end
      default: state_d = IDLE;
    endcase
  end

  assign intr_req = state_q == REQ;
  assign tv_cause = state_q == REQ ? cause_q : win;
  assign tv_base = {mtvec_q[31:2], 2'b00};
  assign trap_vector = mtvec_q[1:0] == 2'b01 ? tv_base + {25'b0, tv_cause, 2'b00} : tv_base;
  assign epc = mepc_q;

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      mie_q <= '0;
      mtvec_q <= MTVEC_RESET;
      mscratch_q <= '0;
      mepc_q <= '0;
      mcause_q <= '0;
      mst_mie_q <= 1'b0;
      mst_mpie_q <= 1'b0;
      state_q <= IDLE;
      cause_q <= '0;
    end else begin
      sync_q <= sync_d;
      mie_q <= mie_d;
      mtvec_q <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q <= mepc_d;
      mcause_q <= mcause_d;
      mst_mie_q <= mst_mie_d;
      mst_mpie_q <= mst_mpie_d;
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end
endmodule

// File: tb/tb_csr_intr_ctrl.sv
// tb_csr_intr_ctrl: directed bench with a spec-level model checked every cycle plus literal expectations
module tb_csr_intr_ctrl;
  localparam int N = 4, S = 2, LOG = 4096;

  logic clk = 1'b0, rst = 1'b0;
  logic [31:0] pc_i = '0, csr_wdata = '0, rdata, trap_vector, epc;
  logic [11:0] csr_addr = 12'h300;
  logic [1:0] csr_op = '0;
  logic csr_illegal, t_intr = 1'b0, e_intr = 1'b0, is_mret = 1'b0, intr_req, intr_ack = 1'b0;
  logic [N-1:0] ext_irq = '0;

  int checks = 0, fails = 0;

  always #5 clk = ~clk;

  csr_intr_ctrl #(.NUM_EXT_IRQ(N), .SYNC_STAGES(S), .MTVEC_RESET(32'h0)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_op(csr_op), .rdata(rdata), .csr_illegal(csr_illegal), .t_intr(t_intr),
    .e_intr(e_intr), .ext_irq(ext_irq), .is_mret(is_mret), .intr_req(intr_req),
    .intr_ack(intr_ack), .trap_vector(trap_vector), .epc(epc)
  );

  // model: architectural CSR contents, trap phase (0 idle, 1 awaiting ack, 2 in handler), input log
  logic m_mie_b, m_mpie_b;
  logic [31:0] m_mie, m_mtvec, m_scr, m_mepc, m_mcause;
  logic [4:0] m_cause;
  int m_phase, m_edges;
  logic [N+1:0] raw_log [LOG];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // mip shows the level that was sampled S-1 edges before the latest one
  function automatic logic [31:0] m_mip();
    logic [31:0] m = '0;
    logic [N+1:0] r = '0;
    int j = m_edges - S + 1;
    if (j >= 1) r = raw_log[j % LOG];
    m[7] = r[0];
    m[11] = r[1];
    for (int i = 0; i < N; i++) m[16 + i] = r[2 + i];
    return m;
  endfunction

  function automatic int m_win(logic [31:0] p);
    if (p[11]) return 11;
    if (p[7]) return 7;
    for (int i = 0; i < N; i++) if (p[16 + i]) return 16 + i;
    return 0;
  endfunction

  function automatic bit m_legal(logic [11:0] a);
    return a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344};
  endfunction

  function automatic logic [31:0] m_read(logic [11:0] a);
    case (a)
      12'h300: return (m_mie_b ? 32'h8 : 32'h0) | (m_mpie_b ? 32'h80 : 32'h0);
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_scr;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return m_mip();
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_tv();
    logic [31:0] base = m_mtvec & ~32'h3;
    int c = m_phase == 1 ? int'(m_cause) : m_win(m_mip() & m_mie);
    return m_mtvec[1:0] == 2'b01 ? base + 32'(c * 4) : base;
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [31:0] p, rd, nv;
    bit wr, take;
    int w;
    if (rst) begin
      m_mie_b <= 1'b0; m_mpie_b <= 1'b0; m_mie <= '0; m_mtvec <= '0; m_scr <= '0;
      m_mepc <= '0; m_mcause <= '0; m_cause <= '0; m_phase <= 0; m_edges <= 0;
    end else begin
      p = m_mip() & m_mie;
      w = m_win(p);
      rd = m_read(csr_addr);
      nv = csr_op == 2'd1 ? csr_wdata : csr_op == 2'd2 ? rd | csr_wdata : rd & ~csr_wdata;
      wr = csr_op != 2'd0 && m_legal(csr_addr);
      take = m_phase == 1 && intr_ack && !is_mret;
      if (wr && csr_addr == 12'h304) m_mie <= nv & 32'h000F_0880;
      if (wr && csr_addr == 12'h305) m_mtvec <= (nv & ~32'h3) | (nv[1:0] == 2'd1 ? 32'h1 : 32'h0);
      if (wr && csr_addr == 12'h340) m_scr <= nv;
      if (take) begin
        m_mepc <= pc_i & ~32'h3;
        m_mcause <= 32'h8000_0000 | 32'(m_cause);
        m_mie_b <= 1'b0;
        m_mpie_b <= m_mie_b;
      end else begin
        if (wr && csr_addr == 12'h341) m_mepc <= nv & ~32'h3;
        if (wr && csr_addr == 12'h342) m_mcause <= nv & 32'h8000_001F;
        if (is_mret) begin
          m_mie_b <= m_mpie_b;
          m_mpie_b <= 1'b1;
        end else if (wr && csr_addr == 12'h300) begin
          m_mie_b <= nv[3];
          m_mpie_b <= nv[7];
        end
      end
      if (m_phase == 0 && p != 0 && m_mie_b) begin
        m_phase <= 1;
        m_cause <= 5'(w);
      end else if (m_phase == 1) m_phase <= take ? 2 : (p == 0 || !m_mie_b) ? 0 : 1;
      else if (m_phase == 2) begin
        if (is_mret) m_phase <= 0;
        else if (p != 0 && m_mie_b) begin
          m_phase <= 1;
          m_cause <= 5'(w);
        end
      end
      raw_log[(m_edges + 1) % LOG] <= {ext_irq, e_intr, t_intr};
      m_edges <= m_edges + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("intr_req", 32'(intr_req), 32'(m_phase == 1));
      chk("trap_vector", trap_vector, m_tv());
      chk("epc", epc, m_mepc);
      chk("rdata", rdata, m_read(csr_addr));
      chk("csr_illegal", 32'(csr_illegal), 32'(!m_legal(csr_addr)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr(logic [11:0] a, logic [1:0] op, logic [31:0] d);
    csr_addr = a; csr_op = op; csr_wdata = d;
    tick();
    csr_op = 2'd0;
  endtask

  task automatic peek(string n, logic [11:0] a, logic [31:0] e);
    csr_addr = a;
    #1;
    chk(n, rdata, e);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_req", 32'(intr_req), 32'h0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_tv", trap_vector, 32'h0);
    peek("rst_mstatus", 12'h300, 32'h0);
    chk("rst_illegal", 32'(csr_illegal), 32'h0);
    peek("rst_mtvec", 12'h305, 32'h0);

    csr(12'h304, 2'd1, 32'h80);
    csr(12'h300, 2'd1, 32'h8);
    t_intr = 1'b1;
    tick(); chk("lat_n", 32'(intr_req), 32'h0);
    tick(); chk("lat_n1", 32'(intr_req), 32'h0);
    tick(); chk("lat_n2", 32'(intr_req), 32'h1);
    pc_i = 32'h104; intr_ack = 1'b1;
    tick();
    intr_ack = 1'b0; t_intr = 1'b0;
    chk("ack_req", 32'(intr_req), 32'h0);
    peek("ack_mepc", 12'h341, 32'h104);
    peek("ack_mcause", 12'h342, 32'h8000_0007);
    peek("ack_mstatus", 12'h300, 32'h80);
    repeat (3) tick();
    is_mret = 1'b1; tick(); is_mret = 1'b0;
    peek("mret_mstatus", 12'h300, 32'h88);

    csr(12'h305, 2'd1, 32'h1001);
    csr(12'h304, 2'd1, 32'h880);
    t_intr = 1'b1; e_intr = 1'b1;
    repeat (3) tick();
    chk("prio_req", 32'(intr_req), 32'h1);
    chk("prio_tv", trap_vector, 32'h102C);

    csr(12'h300, 2'd3, 32'h8);
    tick();
    chk("wd_req", 32'(intr_req), 32'h0);
    chk("wd_epc", epc, 32'h104);
    t_intr = 1'b0; e_intr = 1'b0;
    repeat (3) tick();

    csr(12'h304, 2'd1, 32'h4_0000);
    ext_irq = 4'b0100;
    csr(12'h300, 2'd2, 32'h8);
    repeat (2) tick();
    chk("ext_req", 32'(intr_req), 32'h1);
    chk("ext_tv", trap_vector, 32'h1048);
    pc_i = 32'h206; intr_ack = 1'b1; tick(); intr_ack = 1'b0;
    peek("ext_mepc", 12'h341, 32'h204);
    peek("ext_mcause", 12'h342, 32'h8000_0012);
    tick();
    chk("hdl_req", 32'(intr_req), 32'h0);
    is_mret = 1'b1; tick(); is_mret = 1'b0;
    peek("ret_mstatus", 12'h300, 32'h88);
    chk("ret_epc", epc, 32'h204);
    tick();
    chk("rearm_req", 32'(intr_req), 32'h1);
    pc_i = 32'h300; intr_ack = 1'b1; tick(); intr_ack = 1'b0;
    csr(12'h300, 2'd2, 32'h8);
    tick();
    chk("nest_req", 32'(intr_req), 32'h1);
    pc_i = 32'h400; intr_ack = 1'b1; tick(); intr_ack = 1'b0;
    peek("nest_mepc", 12'h341, 32'h400);
    csr(12'h304, 2'd3, 32'h4_0000);
    is_mret = 1'b1; tick(); is_mret = 1'b0;

    csr(12'h344, 2'd1, 32'hFFFF_FFFF);
    peek("mip_ro", 12'h344, 32'h4_0000);
    peek("ill_rdata", 12'h7C0, 32'h0);
    chk("ill_flag", 32'(csr_illegal), 32'h1);
    csr(12'h7C0, 2'd1, 32'h5);
    csr(12'h305, 2'd1, 32'h1003);
    peek("mtvec_m3", 12'h305, 32'h1000);
    csr(12'h341, 2'd1, 32'h123);
    peek("mepc_lsb", 12'h341, 32'h120);
    csr(12'h342, 2'd1, 32'hFFFF_FFFF);
    peek("mcause_msk", 12'h342, 32'h8000_001F);
    csr(12'h340, 2'd1, 32'hDEAD_BEEF);
    peek("mscratch", 12'h340, 32'hDEAD_BEEF);
    pc_i = 32'h999; intr_ack = 1'b1; tick(); intr_ack = 1'b0;
    csr(12'h300, 2'd1, 32'h8);
    is_mret = 1'b1; tick(); is_mret = 1'b0;
    peek("idle_mret", 12'h300, 32'h80);
    is_mret = 1'b1; csr(12'h300, 2'd1, 32'h8); is_mret = 1'b0;
    peek("mret_wins", 12'h300, 32'h88);

    csr(12'h304, 2'd1, 32'hFFFF_FFFF);
    peek("mie_mask", 12'h304, 32'h000F_0880);
    tick();
    chk("pre_rst_req", 32'(intr_req), 32'h1);
    #2 rst = 1'b1;
    #1 chk("async_rst_req", 32'(intr_req), 32'h0);
    peek("async_rst_mie", 12'h304, 32'h0);
    tick();
    rst = 1'b0;
    ext_irq = '0;
    repeat (3) tick();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
